// File: rtl/mem_access_pkg.sv
// Shared encodings and lane helpers for the load/store front end
// and its load-alignment datapath.
package mem_access_pkg;
  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
    logic [LANES-1:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001 << addr;
      SIZE_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: mask = 4'b1111;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Reserved size or an access that straddles its natural alignment.
  function automatic logic req_error(input logic [1:0] size, input logic [1:0] addr);
    logic err;
    case (size)
      SIZE_BYTE: err = 1'b0;
      SIZE_HALF: err = addr[0];
      SIZE_WORD: err = |addr;
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [LANES*LANE_W-1:0] store_replicate(input logic [1:0] size,
                                                              input logic [LANES*LANE_W-1:0] data);
    logic [LANES*LANE_W-1:0] rep;
    case (size)
      SIZE_BYTE: rep = {LANES{data[LANE_W-1:0]}};
      SIZE_HALF: rep = {2{data[2*LANE_W-1:0]}};
      SIZE_WORD: rep = data;
      default:   rep = 32'h0000_0000;
    endcase
    return rep;
  endfunction
endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword from a RAM read word and
// sign- or zero-extends it to 32 bits.
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] DataOutput,
  input  logic [1:0]  size,
  input  logic [1:0]  addrLow,
  input  logic        isUnsigned,
  output logic [31:0] loadData
);
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  // Lane extraction and extension
  always_comb begin
    laneByte = DataOutput[{addrLow, 3'b000} +: 8];
    laneHalf = addrLow[1] ? DataOutput[31:16] : DataOutput[15:0];
    loadData = 32'h0000_0000;
    case (size)
      SIZE_BYTE: loadData = {{24{~isUnsigned & laneByte[7]}}, laneByte};
      SIZE_HALF: loadData = {{16{~isUnsigned & laneHalf[15]}}, laneHalf};
      SIZE_WORD: loadData = DataOutput;
      default:   loadData = 32'h0000_0000;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a four-lane byte-addressable RAM: one request
// per handshake, registered RAM strobes, aligned/extended load response.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int WidthData     = 32,
  parameter int RAM_ADDR_BITS = 17,
  parameter int ReadLatency   = 1
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     ReqValid,
  output logic                     ReqReady,
  input  logic                     ReqWrite,
  input  logic [1:0]               ReqSize,
  input  logic                     ReqUnsigned,
  input  logic [RAM_ADDR_BITS+1:0] ReqAddress,
  input  logic [WidthData-1:0]     ReqWData,
  output logic                     RespValid,
  output logic [WidthData-1:0]     RespData,
  output logic                     RespError,
  output logic                     RAMEnableByte0LSB,
  output logic                     RAMEnableByte1,
  output logic                     RAMEnableByte2,
  output logic                     RAMEnableByte3MSB,
  output logic                     WriteMemoryByte0LSB,
  output logic                     WriteMemoryByte1,
  output logic                     WriteMemoryByte2,
  output logic                     WriteMemoryByte3MSB,
  output logic [RAM_ADDR_BITS-1:0] AddressRAM,
  output logic [WidthData-1:0]     DataLoad,
  input  logic [WidthData-1:0]     DataOutput
);
  state_t           state;
  logic [1:0]       sizeR;
  logic [1:0]       addrLowR;
  logic             unsignedR;
  logic             writeR;
  logic [1:0]       countR;
  logic [LANES-1:0] enableR;
  logic [LANES-1:0] strobeR;
  logic [31:0]      alignedData;

  assign ReqReady = (state == IDLE) && !Reset;

  assign RAMEnableByte0LSB   = enableR[0];
  assign RAMEnableByte1      = enableR[1];
  assign RAMEnableByte2      = enableR[2];
  assign RAMEnableByte3MSB   = enableR[3];
  assign WriteMemoryByte0LSB = strobeR[0];
  assign WriteMemoryByte1    = strobeR[1];
  assign WriteMemoryByte2    = strobeR[2];
  assign WriteMemoryByte3MSB = strobeR[3];

  mem_load_align uAlign (
    .DataOutput (DataOutput),
    .size       (sizeR),
    .addrLow    (addrLowR),
    .isUnsigned (unsignedR),
    .loadData   (alignedData)
  );

  // Request FSM with registered RAM strobes and response outputs
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      sizeR      <= SIZE_BYTE;
      addrLowR   <= 2'b00;
      unsignedR  <= 1'b0;
      writeR     <= 1'b0;
      countR     <= 2'b00;
      enableR    <= 4'b0000;
      strobeR    <= 4'b0000;
      AddressRAM <= '0;
      DataLoad   <= 32'h0000_0000;
      RespValid  <= 1'b0;
      RespData   <= 32'h0000_0000;
      RespError  <= 1'b0;
    end else begin
      // Strobes live for the ISSUE cycle only; the response is a single pulse.
      enableR   <= 4'b0000;
      strobeR   <= 4'b0000;
      RespValid <= 1'b0;
      RespError <= 1'b0;
      case (state)
        IDLE: begin
          if (ReqValid) begin
            sizeR     <= ReqSize;
            addrLowR  <= ReqAddress[1:0];
            unsignedR <= ReqUnsigned;
            writeR    <= ReqWrite;
            if (req_error(ReqSize, ReqAddress[1:0])) begin
              state     <= RESP;
              RespValid <= 1'b1;
              RespError <= 1'b1;
              RespData  <= 32'h0000_0000;
            end else begin
              state      <= ISSUE;
              enableR    <= lane_mask(ReqSize, ReqAddress[1:0]);
              strobeR    <= lane_mask(ReqSize, ReqAddress[1:0]) & {LANES{ReqWrite}};
              AddressRAM <= ReqAddress[RAM_ADDR_BITS+1:2];
              DataLoad   <= store_replicate(ReqSize, ReqWData);
            end
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (writeR) begin
            state     <= RESP;
            RespValid <= 1'b1;
            RespData  <= 32'h0000_0000;
          end else begin
            state  <= WAIT;
            countR <= 2'(ReadLatency);
          end
        end
        WAIT: begin
          if (countR == 2'd1) begin
            state     <= RESP;
            RespValid <= 1'b1;
            RespData  <= alignedData;
          end else begin
            countR <= countR - 2'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit with a behavioural
// RAM and a byte-array reference model.
module tb_mem_access_unit;
  localparam int LAT = 2;

  logic        CLK;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqUnsigned;
  logic [18:0] ReqAddress;
  logic [31:0] ReqWData;
  logic        RespValid;
  logic [31:0] RespData;
  logic        RespError;
  logic        RAMEnableByte0LSB, RAMEnableByte1, RAMEnableByte2, RAMEnableByte3MSB;
  logic        WriteMemoryByte0LSB, WriteMemoryByte1, WriteMemoryByte2, WriteMemoryByte3MSB;
  logic [16:0] AddressRAM;
  logic [31:0] DataLoad;
  logic [31:0] DataOutput;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] enV;
  logic [3:0] wrV;
  assign enV = {RAMEnableByte3MSB, RAMEnableByte2, RAMEnableByte1, RAMEnableByte0LSB};
  assign wrV = {WriteMemoryByte3MSB, WriteMemoryByte2, WriteMemoryByte1, WriteMemoryByte0LSB};

  mem_access_unit #(.WidthData(32), .RAM_ADDR_BITS(17), .ReadLatency(LAT)) dut (
    .CLK(CLK), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqSize(ReqSize),
    .ReqUnsigned(ReqUnsigned), .ReqAddress(ReqAddress), .ReqWData(ReqWData),
    .RespValid(RespValid), .RespData(RespData), .RespError(RespError),
    .RAMEnableByte0LSB(RAMEnableByte0LSB), .RAMEnableByte1(RAMEnableByte1),
    .RAMEnableByte2(RAMEnableByte2), .RAMEnableByte3MSB(RAMEnableByte3MSB),
    .WriteMemoryByte0LSB(WriteMemoryByte0LSB), .WriteMemoryByte1(WriteMemoryByte1),
    .WriteMemoryByte2(WriteMemoryByte2), .WriteMemoryByte3MSB(WriteMemoryByte3MSB),
    .AddressRAM(AddressRAM), .DataLoad(DataLoad), .DataOutput(DataOutput)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural RAM: per-lane writes, read word appears LAT cycles after the strobe edge
  bit   [31:0] ram [bit [16:0]];
  logic [31:0] rdPipe [LAT];
  always @(posedge CLK) begin
    if (|enV) begin
      for (int j = 0; j < 4; j++)
        if (wrV[j]) ram[AddressRAM][8*j +: 8] <= DataLoad[8*j +: 8];
      rdPipe[0] <= ram[AddressRAM];
    end
    for (int k = 1; k < LAT; k++) rdPipe[k] <= rdPipe[k-1];
  end
  assign DataOutput = rdPipe[LAT-1];

  // Reference memory, byte addressed
  bit [7:0] refMem [0:255];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReq(input bit wr, input bit [1:0] sz, input bit uns, input int addr,
                       input logic [31:0] wd, input bit hold);
    int          n;
    int          waitC;
    int          elapsed;
    bit          err;
    logic [3:0]  mask;
    logic [31:0] expDL;
    logic [31:0] expLoad;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || ((sz == 2'd1) && (addr % 2 != 0)) || ((sz == 2'd2) && (addr % 4 != 0));
    mask = 4'b0000;
    for (int j = 0; j < 4; j++)
      if (j >= (addr % 4) && j < (addr % 4) + n) mask[j] = 1'b1;
    for (int j = 0; j < 4; j++) expDL[8*j +: 8] = wd[8*(j % n) +: 8];
    expLoad = 32'h0;
    if (!err && !wr) begin
      for (int i = 0; i < n; i++) expLoad[8*i +: 8] = refMem[addr + i];
      if (!uns && n < 4 && expLoad[8*n-1])
        for (int b = 8*n; b < 32; b++) expLoad[b] = 1'b1;
    end

    ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqUnsigned = uns;
    ReqAddress = 19'(addr); ReqWData = wd;
    waitC = 0;
    while (ReqReady !== 1'b1 && waitC < 20) begin
      tick();
      waitC++;
    end
    check("accept_ready", {31'b0, ReqReady}, 32'd1);
    check("idle_no_resp", {31'b0, RespValid}, 32'd0);
    tick();
    // Cycle T+1: scramble inputs to show they are ignored while busy
    if (!hold) ReqValid = 1'b0;
    ReqAddress = 19'($urandom); ReqWData = $urandom; ReqSize = 2'($urandom);
    ReqWrite = 1'($urandom); ReqUnsigned = 1'($urandom);
    check("ready_busy", {31'b0, ReqReady}, 32'd0);
    if (err) begin
      check("err_enables", {28'b0, enV}, 32'd0);
      check("err_writes", {28'b0, wrV}, 32'd0);
      check("err_valid", {31'b0, RespValid}, 32'd1);
      check("err_flag", {31'b0, RespError}, 32'd1);
      check("err_data", RespData, 32'd0);
    end else begin
      check("issue_enables", {28'b0, enV}, {28'b0, mask});
      check("issue_writes", {28'b0, wrV}, {28'b0, mask & {4{wr}}});
      check("issue_addr", {15'b0, AddressRAM}, 32'(addr / 4));
      if (wr) begin
        check("issue_dataload", DataLoad, expDL);
        for (int i = 0; i < n; i++) refMem[addr + i] = wd[8*i +: 8];
      end
      elapsed = 1;
      while (RespValid !== 1'b1 && elapsed < 20) begin
        tick();
        elapsed++;
        check("busy_no_strobe", {28'b0, enV}, 32'd0);
        check("busy_not_ready", {31'b0, ReqReady}, 32'd0);
      end
      check("resp_latency", 32'(elapsed), wr ? 32'd2 : 32'(2 + LAT));
      check("resp_error", {31'b0, RespError}, 32'd0);
      check(wr ? "store_data" : "load_data", RespData, expLoad);
    end
  endtask

  initial begin
    int a;
    bit [1:0] s;
    Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00; ReqUnsigned = 1'b0;
    ReqAddress = 19'h0; ReqWData = 32'h0;
    repeat (3) tick();
    check("rst_ready", {31'b0, ReqReady}, 32'd0);
    check("rst_valid", {31'b0, RespValid}, 32'd0);
    check("rst_enables", {28'b0, enV}, 32'd0);
    check("rst_addr", {15'b0, AddressRAM}, 32'd0);
    check("rst_dataload", DataLoad, 32'd0);
    Reset = 1'b0;
    #1;
    check("rst_release_ready", {31'b0, ReqReady}, 32'd1);

    doReq(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    doReq(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 1'b0);
    doReq(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    doReq(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0);
    doReq(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0);
    doReq(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0);
    doReq(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 1'b0);
    doReq(1'b1, 2'd2, 1'b0, 32'h12, 32'h11223344, 1'b0);
    doReq(1'b1, 2'd3, 1'b0, 32'h10, 32'h55667788, 1'b0);
    doReq(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);

    // Reset while a load sits in WAIT: the aborted load must never respond
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqSize = 2'd2; ReqUnsigned = 1'b0; ReqAddress = 19'h10;
    tick();
    ReqValid = 1'b0;
    tick();
    Reset = 1'b1;
    #1;
    check("abort_ready_in_reset", {31'b0, ReqReady}, 32'd0);
    tick();
    check("abort_valid", {31'b0, RespValid}, 32'd0);
    check("abort_enables", {28'b0, enV}, 32'd0);
    check("abort_addr", {15'b0, AddressRAM}, 32'd0);
    check("abort_respdata", RespData, 32'd0);
    Reset = 1'b0;
    #1;
    check("abort_release_ready", {31'b0, ReqReady}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("abort_no_resp", {31'b0, RespValid}, 32'd0);
    end
    doReq(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);

    // ReqValid held high across three back-to-back requests
    doReq(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000C3D2, 1'b1);
    doReq(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1);
    doReq(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 1'b1);
    ReqValid = 1'b0;

    for (int r = 0; r < 40; r++) begin
      a = int'($urandom_range(0, 255));
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'd1) a = a & ~1;
        if (s == 2'd2) a = a & ~3;
      end
      doReq(1'($urandom), s, 1'($urandom), a, $urandom, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front end that sits directly upstream of the four-lane byte-addressable data RAM. It accepts one load or store request per handshake from the processor's memory stage. For each request it generates the per-byte RAMEnable/WriteMemory strobes, the word address and lane-replicated store data. On loads it captures the RAM read word after the read latency, extracts the addressed byte/halfword/word and sign- or zero-extends it into a 32-bit response.

Parameters:
WidthData, 32, data path width (fixed 32; four 8-bit lanes)
RAM_ADDR_BITS, 17, word-address width driven to RAM; byte address is RAM_ADDR_BITS+2 bits
ReadLatency, 1, cycles from RAM strobe edge to valid DataOutput (legal 1..3)

Ports:
CLK  in  1  single clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
ReqValid  in  1  request present
ReqReady  out  1  block can accept; transfer when ReqValid&&ReqReady
ReqWrite  in  1  1=store, 0=load
ReqSize  in  2  00 byte, 01 half, 10 word, 11 reserved
ReqUnsigned  in  1  load zero-extend (1) / sign-extend (0); ignored on stores
ReqAddress  in  RAM_ADDR_BITS+2  byte address
ReqWData  in  32  store data, right-justified
RespValid  out  1  one-cycle completion pulse
RespData  out  32  extended load data; 0 for stores/errors
RespError  out  1  qualified by RespValid; misaligned or reserved size
RAMEnableByte0LSB..RAMEnableByte3MSB  out  1 each  lane enables to RAM
WriteMemoryByte0LSB..WriteMemoryByte3MSB  out  1 each  lane write strobes to RAM
AddressRAM  out  RAM_ADDR_BITS  word address = ReqAddress[RAM_ADDR_BITS+1:2]
DataLoad  out  32  store data to RAM, lane-replicated
DataOutput  in  32  RAM read word

Behaviour:
- Clock CLK; reset Reset is synchronous and active-high.
- States: IDLE, ISSUE, WAIT, RESP. ReqReady = (state==IDLE) && !Reset. Combinational from state.
- Reset (any state, including mid-read): next edge -> IDLE. All RAM strobes, AddressRAM, DataLoad, RespValid, RespData and RespError become 0. An aborted request never produces RespValid.
- Accept at cycle T:
  - Legal request: -> ISSUE.
  - Error (size 11; half with addr[0]=1; word with addr[1:0]!=0): -> RESP directly. RespValid=1 and RespError=1 at T+1. No RAM strobe is ever asserted.
- ISSUE (T+1), registered RAM outputs valid for exactly this cycle:
  - Lane mask: byte -> lane addr[1:0]; half -> lanes {1,0} if addr[1]=0, else {3,2}; word -> all four.
  - RAMEnable = mask. WriteMemory = mask & ReqWrite.
  - Lane 0 = bits [7:0] (little-endian).
  - DataLoad: byte -> ReqWData[7:0] replicated x4; half -> [15:0] replicated x2; word -> unchanged.
  - Store: -> RESP. Load: -> WAIT with latency counter = ReadLatency.
- WAIT: counter decrements each cycle. On the cycle the counter equals 1, sample DataOutput, extract lane(s), extend per ReqUnsigned, register into RespData, then -> RESP.
- RESP: RespValid=1 for one cycle, then -> IDLE. RespError=0 on legal requests.
- Response timing:
  - Store: RespValid at T+2.
  - Load: RespValid at T+2+ReadLatency.
  - Error: RespValid at T+1.
- Outside ISSUE all strobes are 0. AddressRAM and DataLoad hold their last values.
- Request fields are latched at accept. Input changes while busy are ignored.
- ReqValid while busy is not accepted and is not lost; the requester holds it.
- Address wrap: the top byte-address bits beyond RAM_ADDR_BITS+2 do not exist; no wrap logic.

Decomposition:
- Package mem_access_pkg:
  - ReqSize encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_RSVD
  - state enum
  - LANES=4, LANE_W=8
  - function lane_mask(size, addr[1:0])
- One combinational sub-module mem_load_align: inputs DataOutput, size, addr[1:0], unsigned; output is the 32-bit extended word.

Test Plan:
- Store word 0xDEADBEEF @0x10 -> ISSUE cycle: AddressRAM=0x4, all enables and writes=1, DataLoad=0xDEADBEEF. RespValid at T+2, RespError=0.
- Store byte 0xA5 @0x13 -> only Byte3MSB enable/write; DataLoad=0xA5A5A5A5. Then load word @0x10 -> RespData=0xA5ADBEEF at T+3.
- Loads after the above:
  - Signed byte @0x13 -> 0xFFFFFFA5.
  - Unsigned byte @0x13 -> 0x000000A5.
  - Signed half @0x12 -> 0xFFFFA5AD.
  - Unsigned half @0x10 -> 0x0000BEEF.
  - Read strobes have WriteMemory=0.
- Misaligned word store @0x12 and size=11 -> no strobes, RespValid at T+1 with RespError=1. A reload of @0x10 still returns 0xA5ADBEEF.
- Reset asserted during WAIT of a load -> no RespValid ever for that request. ReqReady=1 in the first cycle with Reset low. A new load completes normally.
- ReqValid held high across three requests, ReadLatency=2 build -> each request accepted exactly once. ReqReady=0 while busy. Load RespValid at T+4.
